block_seq_ctrl: RTL and testbench

BLOCK_SEQ_CTRL -- requirements
Module: block_seq_ctrl

---
 rtl/block_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_block_seq_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_seq_ctrl.sv
// Transformer block sequencer: walks LN/projection/attention/FFN engines per head and layer.
// Optional stage watchdog enabled by defining BLOCK_SEQ_WATCHDOG_EN.
module block_seq_ctrl #(
    parameter int N_LAYERS       = 4,
    parameter int N_HEADS        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       ln_done,
    input  logic       proj_done,
    input  logic       qk_matmul_done,
    input  logic       attn_reader_done,
    input  logic       linear1_done,
    input  logic       linear2_done,
    output logic       ln_start,
    output logic       proj_start,
    output logic       qk_matmul_start,
    output logic       attn_reader_start,
    output logic       linear1_start,
    output logic       linear2_start,
    output logic [1:0] proj_sel,
    output logic [7:0] layer_idx,
    output logic [7:0] head_idx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] state
);

    // state    | meaning
    // IDLE     | waiting for start
    // LN1/LN2  | layer norm before attention / before FFN
    // PRJ_Q/K/V| Q, K, V projections for the current head
    // QK_MM    | Q x K^T matmul
    // ATTN_R   | attention readout, then next head or output projection
    // OUT_PRJ  | output projection
    // FFN1/FFN2| feed-forward linears, then next layer or finish
    // FINISH   | one-cycle done pulse
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_LN1 = 4'd1, S_PRJ_Q = 4'd2, S_PRJ_K = 4'd3,
        S_PRJ_V = 4'd4, S_QK_MM = 4'd5, S_ATTN_R = 4'd6, S_OUT_PRJ = 4'd7,
        S_LN2 = 4'd8, S_FFN1 = 4'd9, S_FFN2 = 4'd10, S_FINISH = 4'd11
    } state_t;

    localparam logic [7:0] LAST_LAYER = 8'(N_LAYERS - 1);
    localparam logic [7:0] LAST_HEAD  = 8'(N_HEADS - 1);

    state_t     cur, nxt;
    logic [7:0] nxt_layer, nxt_head;
    logic [1:0] nxt_sel;
    logic       first, eng_done, working, honoured, entering, timeout;

    assign state    = cur;
    assign working  = (cur >= S_LN1) && (cur <= S_FFN2);
    // The start-pulse cycle never counts a done, so residency is at least two cycles.
    assign honoured = working && !first && eng_done;
    assign entering = (nxt != cur);

`ifdef BLOCK_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;
    assign timeout = working && !honoured && (wd_cnt == WD_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        eng_done = 1'b0;
        case (cur)
            S_LN1, S_LN2:                         eng_done = ln_done;
            S_PRJ_Q, S_PRJ_K, S_PRJ_V, S_OUT_PRJ: eng_done = proj_done;
            S_QK_MM:                              eng_done = qk_matmul_done;
            S_ATTN_R:                             eng_done = attn_reader_done;
            S_FFN1:                               eng_done = linear1_done;
            S_FFN2:                               eng_done = linear2_done;
            default:                              eng_done = 1'b0;
        endcase
    end

    always_comb begin
        nxt       = cur;
        nxt_layer = layer_idx;
        nxt_head  = head_idx;
        case (cur)
            S_IDLE: if (start) begin
                nxt       = S_LN1;
                nxt_layer = '0;
                nxt_head  = '0;
            end
            S_LN1:     if (honoured) nxt = S_PRJ_Q;
            S_PRJ_Q:   if (honoured) nxt = S_PRJ_K;
            S_PRJ_K:   if (honoured) nxt = S_PRJ_V;
            S_PRJ_V:   if (honoured) nxt = S_QK_MM;
            S_QK_MM:   if (honoured) nxt = S_ATTN_R;
            S_ATTN_R: if (honoured) begin
                if (head_idx < LAST_HEAD) begin
                    nxt_head = head_idx + 8'd1;
                    nxt      = S_PRJ_Q;
                end else begin
                    nxt = S_OUT_PRJ;
                end
            end
            S_OUT_PRJ: if (honoured) nxt = S_LN2;
            S_LN2:     if (honoured) nxt = S_FFN1;
            S_FFN1:    if (honoured) nxt = S_FFN2;
            S_FFN2: if (honoured) begin
                if (layer_idx < LAST_LAYER) begin
                    nxt_layer = layer_idx + 8'd1;
                    nxt_head  = '0;
                    nxt       = S_LN1;
                end else begin
                    nxt = S_FINISH;
                end
            end
            S_FINISH:  nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
        if (timeout) nxt = S_IDLE;
    end

    always_comb begin
        nxt_sel = 2'd0;
        case (nxt)
            S_PRJ_K:   nxt_sel = 2'd1;
            S_PRJ_V:   nxt_sel = 2'd2;
            S_OUT_PRJ: nxt_sel = 2'd3;
            default:   nxt_sel = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur               <= S_IDLE;
            first             <= 1'b0;
            ln_start          <= 1'b0;
            proj_start        <= 1'b0;
            qk_matmul_start   <= 1'b0;
            attn_reader_start <= 1'b0;
            linear1_start     <= 1'b0;
            linear2_start     <= 1'b0;
            proj_sel          <= 2'd0;
            layer_idx         <= 8'd0;
            head_idx          <= 8'd0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
`ifdef BLOCK_SEQ_WATCHDOG_EN
            wd_cnt            <= '0;
`endif
        end else begin
            cur               <= nxt;
            first             <= entering;
            ln_start          <= entering && (nxt == S_LN1 || nxt == S_LN2);
            proj_start        <= entering && (nxt == S_PRJ_Q || nxt == S_PRJ_K ||
                                              nxt == S_PRJ_V || nxt == S_OUT_PRJ);
            qk_matmul_start   <= entering && (nxt == S_QK_MM);
            attn_reader_start <= entering && (nxt == S_ATTN_R);
            linear1_start     <= entering && (nxt == S_FFN1);
            linear2_start     <= entering && (nxt == S_FFN2);
            proj_sel          <= nxt_sel;
            layer_idx         <= nxt_layer;
            head_idx          <= nxt_head;
            busy              <= (nxt != S_IDLE);
            done              <= (nxt == S_FINISH);
`ifdef BLOCK_SEQ_WATCHDOG_EN
            err               <= timeout;
            if (entering)     wd_cnt <= '0;
            else if (working) wd_cnt <= wd_cnt + 1'b1;
`else
            err               <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_block_seq_ctrl.sv
// Randomized bench for block_seq_ctrl: engine responders feed done pulses, observed start
// events are checked against a stage-order model built from layer/head loops.
module tb_block_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       a_start, b_start;
    logic [5:0] a_din, b_din, a_resp, b_resp, a_frc, a_sout, b_sout;
    logic [1:0] a_sel, b_sel;
    logic [7:0] a_layer, a_head, b_layer, b_head;
    logic       a_busy, a_done, a_err, b_busy, b_done, b_err;
    logic [3:0] a_state, b_state;

    bit a_resp_en, a_block_attn, a_rand_lat;
    int a_cnt[6], b_cnt[6];
    int evq_a[$], evq_b[$], exp_q[$];
    int a_donec = 0, a_errc = 0, b_donec = 0;
    int n_cmp = 0, n_err = 0;

    assign a_din = a_resp | a_frc;
    assign b_din = b_resp;

    block_seq_ctrl #(.N_LAYERS(2), .N_HEADS(2), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .reset(rst_n), .start(a_start),
        .ln_done(a_din[0]), .proj_done(a_din[1]), .qk_matmul_done(a_din[2]),
        .attn_reader_done(a_din[3]), .linear1_done(a_din[4]), .linear2_done(a_din[5]),
        .ln_start(a_sout[0]), .proj_start(a_sout[1]), .qk_matmul_start(a_sout[2]),
        .attn_reader_start(a_sout[3]), .linear1_start(a_sout[4]), .linear2_start(a_sout[5]),
        .proj_sel(a_sel), .layer_idx(a_layer), .head_idx(a_head),
        .busy(a_busy), .done(a_done), .err(a_err), .state(a_state));

    block_seq_ctrl #(.N_LAYERS(1), .N_HEADS(1), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .reset(rst_n), .start(b_start),
        .ln_done(b_din[0]), .proj_done(b_din[1]), .qk_matmul_done(b_din[2]),
        .attn_reader_done(b_din[3]), .linear1_done(b_din[4]), .linear2_done(b_din[5]),
        .ln_start(b_sout[0]), .proj_start(b_sout[1]), .qk_matmul_start(b_sout[2]),
        .attn_reader_start(b_sout[3]), .linear1_start(b_sout[4]), .linear2_start(b_sout[5]),
        .proj_sel(b_sel), .layer_idx(b_layer), .head_idx(b_head),
        .busy(b_busy), .done(b_done), .err(b_err), .state(b_state));

    function automatic int ev(int e, int sel, int l, int h);
        return (e << 20) | (sel << 16) | (l << 8) | h;
    endfunction

    function automatic int eng_of(logic [5:0] s);
        if ($countones(s) != 1) return 7;
        for (int i = 0; i < 6; i++) if (s[i]) return i;
        return 7;
    endfunction

    // Expected engine-start sequence: ln=0 proj=1 qk=2 attn=3 lin1=4 lin2=5.
    function void gen_exp(int nl, int nh);
        exp_q.delete();
        for (int l = 0; l < nl; l++) begin
            exp_q.push_back(ev(0, 0, l, 0));
            for (int h = 0; h < nh; h++) begin
                exp_q.push_back(ev(1, 0, l, h));
                exp_q.push_back(ev(1, 1, l, h));
                exp_q.push_back(ev(1, 2, l, h));
                exp_q.push_back(ev(2, 0, l, h));
                exp_q.push_back(ev(3, 0, l, h));
            end
            exp_q.push_back(ev(1, 3, l, nh - 1));
            exp_q.push_back(ev(0, 0, l, nh - 1));
            exp_q.push_back(ev(4, 0, l, nh - 1));
            exp_q.push_back(ev(5, 0, l, nh - 1));
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) a_cnt[i] = 0;
            a_resp = '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (a_cnt[i] > 0) begin
                    a_cnt[i]  = a_cnt[i] - 1;
                    a_resp[i] = (a_cnt[i] == 0);
                end else begin
                    a_resp[i] = 1'b0;
                end
            end
            if (a_sout != 6'd0) begin
                evq_a.push_back(ev(eng_of(a_sout), int'(a_sel), int'(a_layer), int'(a_head)));
                if (a_resp_en && eng_of(a_sout) < 6 && !(eng_of(a_sout) == 3 && a_block_attn))
                    a_cnt[eng_of(a_sout)] = a_rand_lat ? int'($urandom_range(1, 6)) : 3;
            end
            if (a_done) a_donec++;
            if (a_err) a_errc++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) b_cnt[i] = 0;
            b_resp = '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (b_cnt[i] > 0) begin
                    b_cnt[i]  = b_cnt[i] - 1;
                    b_resp[i] = (b_cnt[i] == 0);
                end else begin
                    b_resp[i] = 1'b0;
                end
            end
            if (b_sout != 6'd0) begin
                evq_b.push_back(ev(eng_of(b_sout), int'(b_sel), int'(b_layer), int'(b_head)));
                if (eng_of(b_sout) < 6) b_cnt[eng_of(b_sout)] = 3;
            end
            if (b_done) b_donec++;
        end
    end

    task automatic pulse_a();
        a_start = 1'b1;
        @(negedge clk); #1;
        a_start = 1'b0;
    endtask

    task automatic wait_a(input int st, input int lay, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk); #1;
            if (int'(a_state) == st && (lay < 0 || int'(a_layer) == lay)) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_start = 1'b1; b_start = 1'b1; a_frc = '1;
        repeat (3) @(negedge clk); #1;
        n_cmp++; if (a_state !== 4'd0 || a_busy !== 1'b0)
            begin n_err++; $display("FAIL reset_state_a: state=%0d busy=%0b want 0/0", a_state, a_busy); end
        n_cmp++; if ({a_sout, a_done, a_err, a_sel} !== 10'd0)
            begin n_err++; $display("FAIL reset_outs_a: starts=%b done=%b err=%b sel=%0d want 0", a_sout, a_done, a_err, a_sel); end
        n_cmp++; if (a_layer !== 8'd0 || a_head !== 8'd0)
            begin n_err++; $display("FAIL reset_idx_a: layer=%0d head=%0d want 0/0", a_layer, a_head); end
        n_cmp++; if (b_state !== 4'd0 || b_busy !== 1'b0)
            begin n_err++; $display("FAIL reset_state_b: state=%0d busy=%0b want 0/0", b_state, b_busy); end
        a_start = 1'b0; b_start = 1'b0; a_frc = '0; rst_n = 1'b1;
        repeat (3) @(negedge clk); #1;
        n_cmp++; if (a_state !== 4'd0 || a_busy !== 1'b0)
            begin n_err++; $display("FAIL idle_hold: state=%0d busy=%0b want 0/0", a_state, a_busy); end
    endtask

    task automatic test_full_job(input bit rnd);
        int base, bd;
        bit ok;
        a_rand_lat = rnd;
        gen_exp(2, 2);
        repeat ($urandom_range(1, 6)) @(negedge clk);
        #1;
        base = evq_a.size(); bd = a_donec;
        pulse_a();
        ok = 1'b0;
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk); #1;
            if (a_donec != bd) ok = 1'b1;
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL full_job_timeout: no done got=%0d want 1", a_donec - bd); end
        repeat (3) @(negedge clk); #1;
        n_cmp++; if (evq_a.size() - base != exp_q.size())
            begin n_err++; $display("FAIL full_job_count: starts=%0d want %0d", evq_a.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < evq_a.size()) begin
                n_cmp++; if (evq_a[base + i] !== exp_q[i])
                    begin n_err++; $display("FAIL full_job_ev%0d: got=%h want %h", i, evq_a[base + i], exp_q[i]); end
            end
        end
        n_cmp++; if (a_donec - bd != 1)
            begin n_err++; $display("FAIL full_job_done: done pulses=%0d want 1", a_donec - bd); end
        n_cmp++; if (a_busy !== 1'b0 || a_state !== 4'd0)
            begin n_err++; $display("FAIL full_job_idle: busy=%0b state=%0d want 0/0", a_busy, a_state); end
        n_cmp++; if (a_layer !== 8'd1 || a_head !== 8'd1)
            begin n_err++; $display("FAIL idx_hold: layer=%0d head=%0d want 1/1", a_layer, a_head); end
        a_rand_lat = 1'b0;
    endtask

    task automatic test_busy_start();
        int base, bd;
        bit ok;
        gen_exp(2, 2);
        base = evq_a.size(); bd = a_donec;
        pulse_a();
        wait_a(5, 1, 400, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL busy_start_wait: state=%0d want QK_MM layer 1", a_state); end
        a_start = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1;
        a_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk); #1;
            if (a_donec != bd) ok = 1'b1;
        end
        repeat (12) @(negedge clk); #1;
        n_cmp++; if (a_donec - bd != 1)
            begin n_err++; $display("FAIL busy_start_done: done pulses=%0d want 1", a_donec - bd); end
        n_cmp++; if (evq_a.size() - base != exp_q.size())
            begin n_err++; $display("FAIL busy_start_count: starts=%0d want %0d", evq_a.size() - base, exp_q.size()); end
        n_cmp++; if (a_state !== 4'd0)
            begin n_err++; $display("FAIL busy_start_idle: state=%0d want 0", a_state); end
    endtask

    task automatic test_early_done();
        a_resp_en = 1'b0;
        pulse_a();
        n_cmp++; if (a_state !== 4'd1) begin n_err++; $display("FAIL early_ln1_entry: state=%0d want 1", a_state); end
        a_frc[0] = 1'b1; a_frc[1] = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (a_state !== 4'd1) begin n_err++; $display("FAIL early_ln1_hold: state=%0d want 1", a_state); end
        @(negedge clk); #1;
        n_cmp++; if (a_state !== 4'd2 || a_sout !== 6'b000010 || a_sel !== 2'd0)
            begin n_err++; $display("FAIL early_prjq_entry: state=%0d starts=%b sel=%0d want 2/000010/0", a_state, a_sout, a_sel); end
        a_frc[0] = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (a_state !== 4'd2) begin n_err++; $display("FAIL early_prjq_hold: state=%0d want 2", a_state); end
        @(negedge clk); #1;
        n_cmp++; if (a_state !== 4'd3 || a_sout !== 6'b000010 || a_sel !== 2'd1)
            begin n_err++; $display("FAIL early_prjk_entry: state=%0d starts=%b sel=%0d want 3/000010/1", a_state, a_sout, a_sel); end
        a_frc[1] = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            n_cmp++; if (a_state !== 4'd3) begin n_err++; $display("FAIL early_no_double: state=%0d want 3", a_state); end
        end
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1; a_resp_en = 1'b1;
    endtask

    task automatic test_reset_mid_job();
        int bd, s;
        bit ok;
        bd = a_donec;
        pulse_a();
        wait_a(9, 0, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rst_mid_wait: state=%0d want FFN1 layer 0", a_state); end
        rst_n = 1'b0; a_start = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (a_state !== 4'd0 || a_busy !== 1'b0)
            begin n_err++; $display("FAIL rst_mid_state: state=%0d busy=%0b want 0/0", a_state, a_busy); end
        n_cmp++; if (a_layer !== 8'd0 || a_head !== 8'd0)
            begin n_err++; $display("FAIL rst_mid_idx: layer=%0d head=%0d want 0/0", a_layer, a_head); end
        n_cmp++; if ({a_sout, a_sel, a_done} !== 9'd0)
            begin n_err++; $display("FAIL rst_mid_outs: starts=%b sel=%0d done=%b want 0", a_sout, a_sel, a_done); end
        rst_n = 1'b1; a_start = 1'b0;
        s = evq_a.size();
        repeat (10) @(negedge clk); #1;
        n_cmp++; if (evq_a.size() != s)
            begin n_err++; $display("FAIL rst_mid_quiet: new starts=%0d want 0", evq_a.size() - s); end
        n_cmp++; if (a_donec != bd || a_state !== 4'd0)
            begin n_err++; $display("FAIL rst_mid_done: done pulses=%0d state=%0d want 0/0", a_donec - bd, a_state); end
    endtask

    task automatic test_watchdog();
        int bd, be;
        bit ok;
        a_block_attn = 1'b1;
        bd = a_donec; be = a_errc;
        pulse_a();
        wait_a(6, -1, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wd_wait: state=%0d want ATTN_R", a_state); end
`ifdef BLOCK_SEQ_WATCHDOG_EN
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk); #1;
            if (k < 16) begin
                n_cmp++; if (a_state !== 4'd6 || a_err !== 1'b0)
                    begin n_err++; $display("FAIL wd_wait_k%0d: state=%0d err=%b want 6/0", k, a_state, a_err); end
            end else begin
                n_cmp++; if (a_err !== 1'b1 || a_state !== 4'd0 || a_busy !== 1'b0)
                    begin n_err++; $display("FAIL wd_fire: err=%b state=%0d busy=%b want 1/0/0", a_err, a_state, a_busy); end
            end
        end
        @(negedge clk); #1;
        n_cmp++; if (a_err !== 1'b0) begin n_err++; $display("FAIL wd_pulse_len: err=%b want 0", a_err); end
        n_cmp++; if (a_donec != bd || a_errc != be + 1)
            begin n_err++; $display("FAIL wd_counts: done=%0d err=%0d want 0/1", a_donec - bd, a_errc - be); end
`else
        repeat (40) @(negedge clk); #1;
        n_cmp++; if (a_state !== 4'd6 || a_errc != be)
            begin n_err++; $display("FAIL wd_off_wait: state=%0d errs=%0d want 6/0", a_state, a_errc - be); end
        n_cmp++; if (a_donec != bd) begin n_err++; $display("FAIL wd_off_done: done=%0d want 0", a_donec - bd); end
        rst_n = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b1;
`endif
        a_block_attn = 1'b0;
    endtask

    task automatic test_degenerate();
        int base, bd;
        bit ok;
        gen_exp(1, 1);
        base = evq_b.size(); bd = b_donec;
        b_start = 1'b1;
        @(negedge clk); #1;
        b_start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); #1;
            if (b_donec != bd) ok = 1'b1;
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL degen_timeout: done=%0d want 1", b_donec - bd); end
        repeat (3) @(negedge clk); #1;
        n_cmp++; if (evq_b.size() - base != exp_q.size())
            begin n_err++; $display("FAIL degen_count: starts=%0d want %0d", evq_b.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < evq_b.size()) begin
                n_cmp++; if (evq_b[base + i] !== exp_q[i])
                    begin n_err++; $display("FAIL degen_ev%0d: got=%h want %h", i, evq_b[base + i], exp_q[i]); end
            end
        end
        n_cmp++; if (b_state !== 4'd0 || b_busy !== 1'b0 || b_donec - bd != 1)
            begin n_err++; $display("FAIL degen_end: state=%0d busy=%b done=%0d want 0/0/1", b_state, b_busy, b_donec - bd); end
    endtask

    initial begin
        rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0; a_frc = '0;
        a_resp_en = 1'b1; a_block_attn = 1'b0; a_rand_lat = 1'b0;
        test_reset();
        test_full_job(1'b0);
        test_full_job(1'b1);
        test_busy_start();
        test_early_done();
        test_reset_mid_job();
        test_watchdog();
        test_degenerate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
